// File: rtl/sum_sched_pkg.sv
// Shared types and default widths for the serial sum-range scheduler.
// The FSM encoding is fixed here so the controller and any debug tooling agree.
package sum_sched_pkg;

  localparam int DEF_N_W   = 4;
  localparam int DEF_SUM_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sum_range_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request after rr_ptr_i, wrapping.
// The pointer register lives in the parent so it only moves on an accepted job.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_req_o
);

  always_comb begin
    logic found;
    int   cand;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    // rr_ptr_i itself is searched last, so the previous winner has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        gnt_o[cand]     = 1'b1;
        gnt_idx_o       = ID_W'(cand);
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/sum_range_scheduler.sv
// Front-end controller for the serial summation datapath: picks one requester
// round-robin, accumulates 1+..+n one add per cycle, returns the tagged result.
module sum_range_scheduler
  import sum_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int N_W     = DEF_N_W,
  parameter  int SUM_W   = DEF_SUM_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [SUM_W-1:0]       rsp_sum,
  input  logic                   rsp_ready,
  output logic                   busy
);

  state_e           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [SUM_W-1:0] sum_q;
  logic [N_W:0]     idx_q;
  logic [N_W-1:0]   n_lat_q;
  logic [ID_W-1:0]  id_lat_q;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req;
  logic [N_W-1:0]     n_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  assign n_sel = req_n[gnt_idx*N_W +: N_W];

  // idx is one bit wider than n so the all-ones bound still reaches equality.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ-1);
      sum_q    <= '0;
      idx_q    <= '0;
      n_lat_q  <= '0;
      id_lat_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            n_lat_q  <= n_sel;
            id_lat_q <= gnt_idx;
            rr_ptr_q <= gnt_idx;
            sum_q    <= '0;
            idx_q    <= (N_W+1)'(1);
            state_q  <= (n_sel == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          sum_q <= sum_q + SUM_W'(idx_q);
          idx_q <= idx_q + 1'b1;
          if (idx_q == {1'b0, n_lat_q}) state_q <= DONE;
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = rsp_valid ? sum_q    : '0;
  assign rsp_id    = rsp_valid ? id_lat_q : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/sum_range_scheduler.md
Name: sum_range_scheduler

Overview:
Shares one serial accumulator among NUM_REQ requesters. Each job asks for the sum 1+2+...+n for a requester-supplied bound n. Requests are picked round-robin and run one at a time; the accumulator performs one add per cycle. Results return on a single valid/ready response channel, tagged with the requester index. The block is the front-end controller for the team's serial summation datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- N_W, 4, width of each bound n; n ranges over 0..2^N_W-1.
- SUM_W, 8, accumulator and result width. The result wraps mod 2^SUM_W.
- ID_W, $clog2(NUM_REQ), width of the response requester tag (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_n  in  NUM_REQ*N_W  packed bounds; requester i owns bits [i*N_W +: N_W].
- req_ready  out  NUM_REQ  one-hot grant pulse; acceptance of the job.
- rsp_valid  out  1  result available.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_sum  out  SUM_W  result value.
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset is asynchronous and active-low.
  - Registers: state=IDLE, rr_ptr=NUM_REQ-1, sum=0, idx=0, n_lat=0, id_lat=0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0.
- Reset asserted mid-job drops that job silently. No response is ever issued for it.
- Requester protocol:
  - Hold req_valid with req_n stable until req_ready is seen.
  - req_valid is never withdrawn by the block.
- FSM state IDLE:
  - If any req_valid is set, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap-around.
  - req_ready[g]=1 in that same cycle (combinational from state and req_valid). At most one bit of req_ready is ever set.
  - At the clock edge:
    - n_lat<=req_n[g], id_lat<=g, rr_ptr<=g, sum<=0, idx<=1.
    - If n_lat would be 0, go to DONE; otherwise go to CALC.
  - With no request pending, stay in IDLE. req_ready stays 0.
- FSM state CALC:
  - Each cycle: sum<=sum+idx (truncated to SUM_W), idx<=idx+1.
  - When idx==n_lat (the last add), go to DONE.
  - Exactly n_lat adds are performed.
  - idx is N_W+1 bits wide so that n=2^N_W-1 terminates correctly.
- FSM state DONE:
  - rsp_valid=1, rsp_sum=sum, rsp_id=id_lat.
  - Hold all three stable until rsp_ready=1, then go to IDLE.
  - No grant is issued in DONE, even if req_valid is high.
- Outside DONE, rsp_sum and rsp_id are driven to 0.
- Latency:
  - Handshake edge to rsp_valid high: n+1 cycles (n=0 gives 1 cycle).
  - Minimum job-to-job spacing: n+2 cycles, because of one IDLE bubble after the response handshake.
- Fairness:
  - The last-granted requester has the lowest priority next time.
  - A continuously requesting requester waits at most NUM_REQ-1 jobs.
- Simultaneous events:
  - rsp_ready asserted while rsp_valid=0 is ignored.
  - A request arriving during CALC or DONE waits; it is evaluated in IDLE.
- busy is combinational from state.

Decomposition:
- Shared package sum_sched_pkg holds:
  - state encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10. Illegal codes return to IDLE.
  - default width constants N_W and SUM_W.
- One sub-module: rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded grant index, any_req.
  - Purely combinational. rr_ptr itself is stored in the parent.
- The parent holds the FSM, the accumulator and the response registers.

Test Plan:
- req_valid[0]=1, n=10, rsp_ready=1 -> req_ready[0] pulses for 1 cycle; 11 cycles later rsp_valid=1 with rsp_sum=55, rsp_id=0 for exactly 1 cycle; busy then falls.
- req_valid[2]=1, n=0 -> rsp_valid 1 cycle after the grant, rsp_sum=0, rsp_id=2.
- All four requesters raise req_valid together with n=1,2,3,4 and rsp_ready=1 -> grants in order 0,1,2,3; responses (id,sum) are (0,1), (1,3), (2,6), (3,10). Then re-raise req 3 and req 0 together -> req 0 is granted first.
- Job n=3 completes with rsp_ready=0 for 5 cycles while req_valid[1]=1 -> rsp_valid, rsp_sum=6 and rsp_id all stay stable; req_ready stays 0. After rsp_ready=1, req 1 is granted 1 cycle later.
- Drop rst_n for 1 cycle mid-CALC (n=10, after 4 adds) -> all outputs are 0 immediately; no response follows. Resubmitting the job yields 55.
- n=15 -> rsp_sum=120 with the default SUM_W=8. With SUM_W=6 -> rsp_sum=56 (120 mod 64).
